// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mult/multu/div/divu with architectural HI/LO and mthi/mtlo writes.
// Done pulses 34 cycles after start; `define MULDIV_DZ_EARLY_EN for 2-cycle divide-by-zero with a dz flag.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
`ifdef MULDIV_DZ_EARLY_EN
  ,
  output logic            dz
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  logic              is_div_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              bz_q;
  logic [XLEN-1:0]   a_raw_q;
  logic [XLEN-1:0]   b_mag_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              done_q;

  logic            accept;
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            dz_start;

  assign accept   = (state_q == S_IDLE) && start;
  assign sgn      = ~op[0];
  assign a_neg    = sgn & a[XLEN-1];
  assign b_neg    = sgn & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign dz_start = op[1] && (b == '0);

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = 5'd0;
          state_d = S_RUN;
`ifdef MULDIV_DZ_EARLY_EN
          if (dz_start) state_d = S_FIX;
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- iteration datapath ----------------
  // Multiply keeps {partial_hi, multiplier}; each step adds the multiplicand and shifts right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  // Divide keeps {remainder, dividend->quotient}; each step shifts left and trial-subtracts.
  logic [2*XLEN:0]   div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q, 1'b0};
    div_ge    = (div_shift[2*XLEN:XLEN] >= {1'b0, b_mag_q});
    div_diff  = div_shift[2*XLEN-1:XLEN] - b_mag_q;
    div_next  = div_ge ? {div_diff, div_shift[XLEN-1:1], 1'b1} : div_shift[2*XLEN-1:0];
  end

  // ---------------- sign fix-up / result select ----------------
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div_q) begin
      if (bz_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_lo = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        res_hi = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      a_raw_q   <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        is_div_q  <= op[1];
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        bz_q      <= dz_start;
        a_raw_q   <= a;
        b_mag_q   <= b_mag;
        acc_q     <= {{XLEN{1'b0}}, a_mag};
      end else if (state_q == S_RUN) begin
        acc_q <= is_div_q ? div_next : mul_next;
      end

      done_q <= (state_q == S_FIX);

      // mthi/mtlo share the accept edge with start; the later FIX write wins.
      if (state_q == S_FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == S_IDLE) begin
        if (hi_we) hi_q <= wd;
        if (lo_we) lo_q <= wd;
      end
    end
  end

`ifdef MULDIV_DZ_EARLY_EN
  logic dz_q;

  always_ff @(posedge clk) begin
    if (reset) dz_q <= 1'b0;
    else       dz_q <= (state_q == S_FIX) && is_div_q && bz_q;
  end

  assign dz = dz_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: directed vectors plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wd, hi, lo;
  logic        busy, done;
`ifdef MULDIV_DZ_EARLY_EN
  logic        dz;
`endif

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
`ifdef MULDIV_DZ_EARLY_EN
    , .dz(dz)
`endif
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          busyc;
    logic        dz;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass = 0;
  int   total = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Reference: MIPS semantics written directly with 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
        else            p = {x % y, x / y};
      end
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_hi", 64'(hi), 64'(e.hi));
          chk("result_lo", 64'(lo), 64'(e.lo));
          chk("latency", 64'(cyc - e.t0), 64'(e.lat));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busyc));
          chk("busy_in_done", 64'(busy), 64'(0));
`ifdef MULDIV_DZ_EARLY_EN
          chk("dz_flag", 64'(dz), 64'(e.dz));
`endif
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge; waits for idle, drives start for one edge, returns at the negedge after.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic hw, input logic [31:0] w);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout_fail("wait_idle");
    e.hi = eh; e.lo = el; e.lat = 34; e.busyc = 33; e.dz = 1'b0; e.t0 = cyc;
`ifdef MULDIV_DZ_EARLY_EN
    if (o[1] && y == 32'h0) begin
      e.lat = 2; e.busyc = 1; e.dz = 1'b1;
    end
`endif
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y; hi_we = hw; wd = w;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    a = $urandom(); b = $urandom();
    @(negedge clk);
  endtask

  task automatic issue_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    model(o, x, y, eh, el);
    issue(o, x, y, eh, el, 1'b0, 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) timeout_fail("drain");
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       pick = 32'h0;
      1:       pick = 32'h1;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = 32'h8000_0000;
      4:       pick = 32'($urandom_range(0, 20));
      default: pick = $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] hsave;
    int          d0;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = 32'h0; b = 32'h0; wd = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-derived results.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'h0);
    issue(2'b00, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32'h0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'h0);
    issue(2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 32'h0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 32'h0);
    issue(2'b11, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 32'h0);
    issue(2'b10, 32'hFFFF_FF00, 32'h0,         32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0, 32'h0);
    drain();

    // Mid-operation start and mthi must both be ignored.
    issue(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    hsave = hi;
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; hi_we = 1'b1; wd = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    @(negedge clk);
    chk("midop_hi_hold", 64'(hi), 64'(hsave));
    chk("midop_busy", 64'(busy), 64'(1));
    drain();
    chk("after_midop_lo", 64'(lo), 64'(333));

    // mthi / mtlo while idle.
    hi_we = 1'b1; wd = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    @(negedge clk);
    chk("mthi", 64'(hi), 64'(32'h0000_DEAD));
    chk("mthi_lo_kept", 64'(lo), 64'(333));
    lo_we = 1'b1; wd = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    @(negedge clk);
    chk("mtlo", 64'(lo), 64'(32'h0000_BEEF));
    chk("mtlo_hi_kept", 64'(hi), 64'(32'h0000_DEAD));

    // Start and mthi on the same edge: mt lands now, result overwrites later.
    issue(2'b00, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b1, 32'h0000_CAFE);
    chk("start_mthi_same_edge", 64'(hi), 64'(32'h0000_CAFE));
    drain();

    // Reset during iteration 15 of a divu: everything clears and no done follows.
    issue(2'b11, 32'd1000000, 32'd13, 32'd1, 32'd76923, 1'b0, 32'h0);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midreset_busy", 64'(busy), 64'(0));
    chk("midreset_done", 64'(done), 64'(0));
    chk("midreset_hi", 64'(hi), 64'(0));
    chk("midreset_lo", 64'(lo), 64'(0));
    reset = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
    issue_model(2'b11, 32'd1000000, 32'd13);
    drain();

    // Randomized traffic, mostly back-to-back (start lands in the done cycle).
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drain();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue_model(2'($urandom_range(0, 3)), pick(), pick());
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
